recip_byte_seq: RTL and testbench

//  Byte-serial front/back end for the combinational 24-bit reciprocal core.

---
 rtl/recip_byte_seq.sv | 116 +++++++++++
 tb/tb_recip_byte_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/recip_byte_seq.sv
// Byte-serial front/back end for the combinational reciprocal core: gathers an operand over
// handshaked byte transfers, captures the core result for one cycle, then streams it back out.
module recip_byte_seq #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_abs,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_core_data,
    output logic              o_core_abs,
    input  logic [DATA_W-1:0] i_core_data,
    input  logic              i_core_sat,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sat,
    output logic              o_busy
);

    localparam int unsigned NBYTES  = DATA_W / BYTE_W;
    localparam logic [1:0]  LastCnt = 2'(NBYTES - 1);

    typedef enum logic [1:0] {
        StLoad,
        StCalc,
        StSend
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              abs_q, abs_d;
    logic              sat_q, sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            operand_q <= '0;
            result_q  <= '0;
            abs_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            abs_q     <= abs_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        result_d  = result_q;
        abs_d     = abs_q;
        sat_d     = sat_q;
        // Clear wins over any handshake in the same cycle; data registers keep their values.
        if (i_clear) begin
            state_d = StLoad;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (i_valid) begin
                        operand_d = {operand_q[DATA_W-BYTE_W-1:0], i_byte};
                        if (cnt_q == LastCnt) begin
                            cnt_d   = '0;
                            abs_d   = i_abs;
                            state_d = StCalc;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                StCalc: begin
                    result_d = i_core_data;
                    sat_d    = i_core_sat;
                    state_d  = StSend;
                end
                StSend: begin
                    if (i_ready) begin
                        result_d = result_q << BYTE_W;
                        if (cnt_q == LastCnt) begin
                            cnt_d   = '0;
                            state_d = StLoad;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_ready     = (state_q == StLoad);
    assign o_valid     = (state_q == StSend);
    assign o_busy      = (state_q == StCalc) || (state_q == StSend);
    assign o_byte      = result_q[DATA_W-1 -: BYTE_W];
    assign o_core_data = operand_q;
    assign o_core_abs  = abs_q;
    assign o_sat       = sat_q;

endmodule

// File: tb/tb_recip_byte_seq.sv
// Bench for recip_byte_seq: queue-based transaction model checked every cycle, directed scenarios
// with literal expectations, then a randomized soak.
module tb_recip_byte_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_byte;
    logic        i_valid, o_ready, i_abs, i_clear;
    logic [23:0] o_core_data, i_core_data;
    logic        o_core_abs, i_core_sat;
    logic [7:0]  o_byte;
    logic        o_valid, i_ready, o_sat, o_busy;

    int n_cmp = 0;
    int n_err = 0;
    bit stub_mode = 1'b0;
    logic [7:0] got[$];

    recip_byte_seq dut (
        .clk(clk), .rst_n(rst_n), .i_byte(i_byte), .i_valid(i_valid), .o_ready(o_ready),
        .i_abs(i_abs), .i_clear(i_clear), .o_core_data(o_core_data), .o_core_abs(o_core_abs),
        .i_core_data(i_core_data), .i_core_sat(i_core_sat), .o_byte(o_byte), .o_valid(o_valid),
        .i_ready(i_ready), .o_sat(o_sat), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Stand-in reciprocal core: floor((2^24-1)/|x|), saturating on zero; or a fixed stub.
    function automatic logic [24:0] core_f(input logic [23:0] x, input logic a);
        logic [23:0] v;
        if (stub_mode) return {1'b1, 24'hABCDEF};
        v = (a && x[23]) ? (~x + 24'd1) : x;
        if (v == 24'd0) return {1'b1, 24'hFFFFFF};
        return {1'b0, 24'hFFFFFF / v};
    endfunction

    assign {i_core_sat, i_core_data} = core_f(o_core_data, o_core_abs);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: bytes collected, one pending calc slot, queue of bytes to emit.
    int          m_in;
    logic [23:0] m_op;
    logic        m_abs, m_sat, m_calc;
    logic [24:0] m_r;
    logic [7:0]  m_out[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in = 0; m_op = '0; m_abs = 1'b0; m_sat = 1'b0; m_calc = 1'b0;
            m_out.delete();
        end else if (i_clear) begin
            m_in = 0; m_calc = 1'b0;
            m_out.delete();
        end else if (m_calc) begin
            m_r = core_f(m_op, m_abs);
            m_sat = m_r[24];
            for (int i = 0; i < 3; i++) m_out.push_back(m_r[23-8*i -: 8]);
            m_calc = 1'b0;
        end else if (m_out.size() > 0) begin
            if (i_ready) void'(m_out.pop_front());
        end else if (i_valid) begin
            m_op = {m_op[15:0], i_byte};
            m_in++;
            if (m_in == 3) begin
                m_in = 0; m_abs = i_abs; m_calc = 1'b1;
            end
        end
    end

    always @(posedge clk) if (rst_n && o_valid && i_ready) got.push_back(o_byte);

    always @(negedge clk) begin
        if (rst_n) begin
            chk("o_ready", o_ready, !m_calc && m_out.size() == 0);
            chk("o_valid", o_valid, m_out.size() > 0);
            chk("o_busy", o_busy, m_calc || m_out.size() > 0);
            chk("o_core_data", o_core_data, m_op);
            chk("o_core_abs", o_core_abs, m_abs);
            chk("o_sat", o_sat, m_sat);
            if (m_out.size() > 0) chk("o_byte", o_byte, m_out[0]);
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input logic a);
        int n = 0;
        i_byte = b; i_abs = a; i_valid = 1'b1;
        while (!o_ready && n < 30) begin @(negedge clk); n++; end
        if (!o_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: byte %0h not accepted, expected acceptance", b);
        end
        @(negedge clk);
        i_valid = 1'b0; i_abs = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (got.size() < n && k < 100) begin @(negedge clk); k++; end
        if (got.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: got %0d bytes, expected %0d", got.size(), n);
        end
    endtask

    task automatic chk_got(input string name, input logic [23:0] exp);
        for (int i = 0; i < 3; i++)
            chk(name, (got.size() > i) ? got[i] : 8'hxx, exp[23-8*i -: 8]);
        chk({name, "_count"}, got.size(), 3);
        got.delete();
    endtask

    logic [24:0] e;

    initial begin
        rst_n = 1'b0; i_byte = '0; i_valid = 1'b0; i_abs = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_core_data", o_core_data, 0);
        chk("rst_sat", o_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);

        // Stub core: operand/abs forwarding, latency and output order.
        stub_mode = 1'b1;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        chk("t2_core_data", o_core_data, 24'h123456);
        chk("t2_core_abs", o_core_abs, 1);
        chk("t2_calc_valid", o_valid, 0);
        chk("t2_calc_busy", o_busy, 1);
        @(negedge clk);
        chk("t2_first_valid", o_valid, 1);
        chk("t2_first_byte", o_byte, 8'hAB);
        chk("t2_sat", o_sat, 1);
        wait_bytes(3);
        chk_got("t2_out", 24'hABCDEF);

        // Backpressure: five stalled cycles before each output byte.
        stub_mode = 1'b0;
        i_ready = 1'b0;
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b1);
        for (int b = 0; b < 3; b++) begin
            i_ready = 1'b0;
            repeat (5) @(negedge clk);
            i_ready = 1'b1;
            @(negedge clk);
        end
        e = core_f(24'h800003, 1'b1);
        chk_got("t3_out", e[23:0]);

        // Toggling i_valid, then a fourth byte offered straight into CALC.
        send_byte(8'h11, 1'b0);
        @(negedge clk);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("t4_first_op_count", got.size(), 3);
        e = core_f(24'h112233, 1'b0);
        chk_got("t4_out", e[23:0]);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        chk("t4_second_op", o_core_data, 24'h445566);
        wait_bytes(3);
        got.delete();

        // Clear mid-operand, then reload with the real core model.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("t5_core_data", o_core_data, 24'h001000);
        chk("t6_calc_valid", o_valid, 0);
        @(negedge clk);
        chk("t6_latency_valid", o_valid, 1);
        chk("t6_sat", o_sat, 0);
        wait_bytes(3);
        chk_got("t6_out", 24'h000FFF);

        // Asynchronous reset while stalled in SEND.
        i_ready = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid", o_valid, 0);
        chk("t1_busy", o_busy, 0);
        chk("t1_core_data", o_core_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        i_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready_after", o_ready, 1);

        // Random soak against the model.
        for (int c = 0; c < 4000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_byte  = 8'($urandom);
            i_abs   = 1'($urandom_range(0, 1));
            i_ready = ($urandom_range(0, 3) != 0);
            i_clear = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
